// File: rtl/small_fallthrough_fifo_if.sv
// Handshake and status bundle for small_fallthrough_fifo.
//   din/wr_en/rd_en : producer/consumer requests toward the FIFO
//   dout            : head-of-queue word (fall-through)
//   full/nearly_full/prog_full/empty : occupancy decodes
//   overflow/underflow : sticky error flags
// master = the FIFO user, slave = the FIFO itself.
interface small_fallthrough_fifo_if #(
  parameter int unsigned WIDTH = 72
);
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, prog_full, empty, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, prog_full, empty, overflow, underflow
  );
endinterface

// File: rtl/small_fallthrough_fifo.sv
// Register-based first-word-fall-through FIFO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears pointers, depth and error flags
//   fifo  : slave side of small_fallthrough_fifo_if (data, push/pop, flags)
// dout always shows the head entry; a pop takes effect on the same edge with no
// read-latency cycle. Flags decode the registered occupancy counter.
module small_fallthrough_fifo #(
  parameter int unsigned WIDTH               = 72,
  parameter int unsigned MAX_DEPTH_BITS      = 3,
  parameter int unsigned PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  small_fallthrough_fifo_if.slave      fifo
);

  localparam int unsigned DEPTH = 2**MAX_DEPTH_BITS;
  localparam int unsigned PW    = MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PROG_FULL_C = CW'(PROG_FULL_THRESHOLD);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    depth;
  logic             overflow_q;
  logic             underflow_q;

  logic             full_c;
  logic             empty_c;
  logic             wr_eff_c;
  logic             rd_eff_c;

  // Occupancy decodes
  assign full_c   = (depth == DEPTH_C);
  assign empty_c  = (depth == '0);

  // A blocked side is simply dropped; the other side still proceeds
  assign wr_eff_c = fifo.wr_en & ~full_c;
  assign rd_eff_c = fifo.rd_en & ~empty_c;

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_eff_c) begin
      mem[wr_ptr] <= fifo.din;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      depth       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_eff_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_eff_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_eff_c, rd_eff_c})
        2'b10:   depth <= depth + CW'(1);
        2'b01:   depth <= depth - CW'(1);
        default: depth <= depth;
      endcase
      if (fifo.wr_en && full_c) begin
        overflow_q <= 1'b1;
      end
      if (fifo.rd_en && empty_c) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign fifo.dout        = mem[rd_ptr];
  assign fifo.full        = full_c;
  assign fifo.empty       = empty_c;
  assign fifo.nearly_full = (depth >= NEAR_FULL_C);
  assign fifo.prog_full   = (depth >= PROG_FULL_C);
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;

endmodule

// File: tb/tb_small_fallthrough_fifo.sv
// Directed bench for small_fallthrough_fifo at WIDTH=8, MAX_DEPTH_BITS=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_small_fallthrough_fifo;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  small_fallthrough_fifo_if #(.WIDTH(8)) bus ();

  small_fallthrough_fifo #(
    .WIDTH(8),
    .MAX_DEPTH_BITS(3),
    .PROG_FULL_THRESHOLD(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic f,
                           input logic nf, input logic pf);
    chk({tag, ".empty"},       32'(bus.empty),       32'(e));
    chk({tag, ".full"},        32'(bus.full),        32'(f));
    chk({tag, ".nearly_full"}, 32'(bus.nearly_full), 32'(nf));
    chk({tag, ".prog_full"},   32'(bus.prog_full),   32'(pf));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    bus.din   = 8'h11;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;

    // Reset held with a write request pending
    @(negedge clk);
    tick();
    chk_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.overflow",  32'(bus.overflow),  32'd0);
    chk("rst.underflow", 32'(bus.underflow), 32'd0);

    // Release and write 0xA5
    reset   = 1'b1;
    bus.din = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    chk("first.empty", 32'(bus.empty), 32'd0);
    chk("first.dout",  32'(bus.dout),  32'hA5);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("first.pop_empty", 32'(bus.empty), 32'd1);

    // Fill 0x01..0x08 with flag progression
    for (int i = 1; i <= 8; i++) begin
      bus.din   = 8'(i);
      bus.wr_en = 1'b1;
      tick();
      chk_flags($sformatf("fill%0d", i), 1'b0, (i == 8), (i >= 7), (i >= 7));
    end
    chk("fill.overflow_pre", 32'(bus.overflow), 32'd0);
    bus.din = 8'h09;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf.full",     32'(bus.full),     32'd1);
    chk("ovf.overflow", 32'(bus.overflow), 32'd1);

    // Drain and check order
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d.dout", i), 32'(bus.dout), 32'(i));
      bus.rd_en = 1'b1;
      tick();
    end
    bus.rd_en = 1'b0;
    chk_flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drained.underflow", 32'(bus.underflow), 32'd0);

    // Fall-through then immediate pop
    bus.din   = 8'h3C;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("ft.dout",  32'(bus.dout),  32'h3C);
    chk("ft.empty", 32'(bus.empty), 32'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("ft.pop_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push/pop at depth 4 for 20 cycles
    for (int i = 0; i < 4; i++) begin
      bus.din   = 8'(8'h40 + i);
      bus.wr_en = 1'b1;
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sim%0d.dout", k), 32'(bus.dout), 32'(8'h40 + k));
      bus.din   = 8'(8'h44 + k);
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk_flags("sim.end", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("simdrain%0d.dout", i), 32'(bus.dout), 32'(8'h54 + i));
      bus.rd_en = 1'b1;
      tick();
    end
    bus.rd_en = 1'b0;
    chk("simdrain.empty",     32'(bus.empty),     32'd1);
    chk("simdrain.underflow", 32'(bus.underflow), 32'd0);

    // Push+pop on empty: write wins, underflow sets
    bus.din   = 8'h77;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("ec.dout",      32'(bus.dout),      32'h77);
    chk("ec.empty",     32'(bus.empty),     32'd0);
    chk("ec.underflow", 32'(bus.underflow), 32'd1);

    // Bring depth to 5
    for (int i = 0; i < 4; i++) begin
      bus.din   = 8'(8'h80 + i);
      bus.wr_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    chk_flags("d5", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("d5.dout", 32'(bus.dout), 32'h77);

    // Asynchronous reset pulse between edges
    #1;
    reset = 1'b0;
    #1;
    chk_flags("arst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arst.overflow",  32'(bus.overflow),  32'd0);
    chk("arst.underflow", 32'(bus.underflow), 32'd0);
    #1;
    reset = 1'b1;
    @(negedge clk);

    // Refill after reset: a full pass proves storage starts from a clean pointer
    for (int i = 0; i < 8; i++) begin
      bus.din   = 8'(8'h90 + i);
      bus.wr_en = 1'b1;
      tick();
      if (i == 0) chk("post.dout0", 32'(bus.dout), 32'h90);
    end
    bus.wr_en = 1'b0;
    chk_flags("post.full", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post%0d.dout", i), 32'(bus.dout), 32'(8'h90 + i));
      bus.rd_en = 1'b1;
      tick();
    end
    bus.rd_en = 1'b0;
    chk("post.empty", 32'(bus.empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/small_fallthrough_fifo.md
Name: small_fallthrough_fifo

Overview:
- Parameterised, register-based first-word-fall-through FIFO used as the small request and read-data buffers in the SRAM-backed packet/filter pipeline.
- The head word is always presented on dout whenever the FIFO is non-empty. Asserting rd_en pops that word; no read-latency cycle is needed.
- Provides full, nearly_full, programmable-full and empty flags for upstream write throttling, plus sticky overflow/underflow error flags.

Parameters:
WIDTH, 72, data word width in bits (instantiated at 73 and 2+2*SRAM_ADDR_WIDTH).
MAX_DEPTH_BITS, 3, log2 of the storage depth; DEPTH = 2**MAX_DEPTH_BITS entries.
PROG_FULL_THRESHOLD, 2**MAX_DEPTH_BITS-1, occupancy at or above which prog_full asserts.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  asynchronous, active-low reset (0 = reset).
din  input  WIDTH  write data.
wr_en  input  1  push din on the clock edge.
rd_en  input  1  pop the head word on the clock edge.
dout  output  WIDTH  head-of-queue word (fall-through).
full  output  1  occupancy == DEPTH.
nearly_full  output  1  occupancy >= DEPTH-1.
prog_full  output  1  occupancy >= PROG_FULL_THRESHOLD.
empty  output  1  occupancy == 0.
overflow  output  1  sticky: a write was attempted while full.
underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- State:
  - DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr, MAX_DEPTH_BITS bits each; both wrap modulo DEPTH.
  - depth counter, MAX_DEPTH_BITS+1 bits, range 0..DEPTH.
- Reset (reset==0, asynchronous, takes effect immediately):
  - wr_ptr, rd_ptr, depth = 0; overflow, underflow = 0.
  - Outputs: empty=1, full=0, nearly_full=0, prog_full=0.
  - Array contents are not reset.
- Reset mid-operation discards all queued data. The first edge after release behaves like the first edge of an empty FIFO.
- Flags are combinational decodes of the registered depth counter, so they update the cycle after the causing edge.
- dout = array[rd_ptr], combinational from registered state.
  - Valid whenever empty==0.
  - Don't-care while empty; benches must not check it then.
- Write, effective when wr_en=1 and full=0: array[wr_ptr] <= din; wr_ptr increments.
- Read, effective when rd_en=1 and empty=0: rd_ptr increments. The next word, if any, appears on dout after that edge.
- Depth update per edge:
  - +1 on an effective write only.
  - -1 on an effective read only.
  - Unchanged when both are effective, or neither is.
- Simultaneous wr_en and rd_en:
  - When empty: the write is performed and the read is ignored (no same-cycle bypass); underflow sets. The next cycle has depth=1 and dout=din.
  - When full: the read is performed and the write is ignored; overflow sets. Depth becomes DEPTH-1.
  - Otherwise: both are performed.
- Write latency: a word written at edge N is visible on dout (if it is the head) and empty deasserts after edge N.
- Error flags:
  - Write while full: data dropped, state unchanged, overflow sets.
  - Read while empty: no-op, underflow sets.
  - Both flags stay set until reset. A simulation-only $display on each event is permitted.
- Pointer wrap: after DEPTH writes and DEPTH reads, the pointers return to 0 and ordering is preserved.
- Throughput: one write and one read per cycle sustained, with no bubbles.

Test Plan:
- Reset: hold reset=0 with wr_en=1 -> empty=1, full=0, nearly_full=0, prog_full=0, overflow=0, underflow=0. After release plus one write of 0xA5 (WIDTH=8), empty=0 and dout=0xA5 on the next cycle.
- Fill/order (WIDTH=8, MAX_DEPTH_BITS=3):
  - Write 0x01..0x08 on consecutive cycles -> nearly_full after the 7th write, full after the 8th.
  - A 9th write is dropped and overflow=1.
  - Then read 8 times -> dout sequence 0x01..0x08, empty after the 8th read.
- Fall-through: write 0x3C into an empty FIFO -> dout=0x3C the cycle after. Assert rd_en that cycle -> empty=1 on the next cycle.
- Simultaneous: with depth=4, hold wr_en=rd_en=1 for 20 cycles with an incrementing din -> depth stays 4, output stays in order, flags unchanged, pointers wrap twice.
- Empty corner: on an empty FIFO, assert rd_en=wr_en=1 with din=0x77 -> depth=1, dout=0x77, underflow=1.
- Async reset mid-stream: with depth=5, pulse reset low between clock edges -> empty=1 and full=0 immediately without a clock edge. Subsequent writes start from pointer 0.
